// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one data-memory access per memory op over a
// valid/ack bus and assembles the MEM/WB bundle, flagging misalignment and bus timeouts.
module mem_lsu #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic        mem_whilo,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_sel,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stallreq,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_whilo,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic f_is_mem(input logic [7:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: f_is_mem = 1'b1;
            default: f_is_mem = 1'b0;
        endcase
    endfunction

    function automatic logic f_is_load(input logic [7:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: f_is_load = 1'b1;
            default: f_is_load = 1'b0;
        endcase
    endfunction

    // Access size code: 0 = byte, 1 = halfword, 2 = word.
    function automatic logic [1:0] f_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: f_size = 2'd0;
            OP_LH, OP_LHU, OP_SH: f_size = 2'd1;
            default:              f_size = 2'd2;
        endcase
    endfunction

    function automatic logic f_misaligned(input logic [7:0] op, input logic [1:0] off);
        case (f_size(op))
            2'd1:    f_misaligned = off[0];
            2'd2:    f_misaligned = (off != 2'b00);
            default: f_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f_sel(input logic [7:0] op, input logic [1:0] off);
        case (f_size(op))
            2'd0: begin
                case (off)
                    2'b00:   f_sel = 4'b1000;
                    2'b01:   f_sel = 4'b0100;
                    2'b10:   f_sel = 4'b0010;
                    default: f_sel = 4'b0001;
                endcase
            end
            2'd1:    f_sel = off[1] ? 4'b0011 : 4'b1100;
            default: f_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_store_data(input logic [7:0] op, input logic [31:0] reg2);
        case (f_size(op))
            2'd0:    f_store_data = {4{reg2[7:0]}};
            2'd1:    f_store_data = {2{reg2[15:0]}};
            default: f_store_data = reg2;
        endcase
    endfunction

    // Big-endian lane pick: offset 0 is the most significant byte of the word.
    function automatic logic [31:0] f_load_data(input logic [7:0] op, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = w[31:24];
            2'b01:   b = w[23:16];
            2'b10:   b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (op)
            OP_LB:   f_load_data = {{24{b[7]}}, b};
            OP_LBU:  f_load_data = {24'd0, b};
            OP_LH:   f_load_data = {{16{h[15]}}, h};
            OP_LHU:  f_load_data = {16'd0, h};
            default: f_load_data = w;
        endcase
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        rdata_r;
    logic               err_r;

    logic [1:0]         off_s;
    logic               mem_op_s;
    logic               load_s;
    logic               misal_s;
    logic               timeout_s;

    assign off_s     = mem_mem_addr[1:0];
    assign mem_op_s  = f_is_mem(mem_aluop);
    assign load_s    = f_is_load(mem_aluop);
    assign misal_s   = f_misaligned(mem_aluop, off_s);
    // Abort once the counter is about to reach TIMEOUT-1, so dmem_req spans TIMEOUT cycles.
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT - 2));

    // State register, timeout counter, captured read data and error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    err_r <= 1'b0;
                end
                ST_BUSY: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (dmem_ack) begin
                        rdata_r <= dmem_rdata;
                        err_r   <= 1'b0;
                    end else if (timeout_s) begin
                        err_r <= 1'b1;
                    end
                end
                default: cnt_r <= {CNT_W{1'b0}};
            endcase
        end
    end

    // Next-state logic; ack takes priority over the timeout threshold.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s && !misal_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dmem_ack || timeout_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode: bus request, stall, write-back bundle and one-cycle error flags.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_sel   = 4'd0;
        dmem_wdata = 32'd0;
        stallreq   = 1'b0;
        wb_wd      = 5'd0;
        wb_wreg    = 1'b0;
        wb_wdata   = 32'd0;
        wb_hi      = 32'd0;
        wb_lo      = 32'd0;
        wb_whilo   = 1'b0;
        misalign   = 1'b0;
        bus_err    = 1'b0;
        if (!rst) begin
            stallreq = 1'b0;
        end else begin
            wb_wd    = mem_wd;
            wb_hi    = mem_hi;
            wb_lo    = mem_lo;
            wb_wdata = mem_wdata;
            case (state_r)
                ST_IDLE: begin
                    if (!mem_op_s) begin
                        wb_wreg  = mem_wreg;
                        wb_whilo = mem_whilo;
                    end else if (misal_s) begin
                        misalign = 1'b1;
                    end else begin
                        dmem_req = 1'b1;
                        stallreq = 1'b1;
                    end
                end
                ST_BUSY: begin
                    dmem_req = 1'b1;
                    stallreq = 1'b1;
                end
                ST_DONE: begin
                    if (err_r) begin
                        bus_err = 1'b1;
                    end else if (load_s) begin
                        wb_wreg  = mem_wreg;
                        wb_wdata = f_load_data(mem_aluop, off_s, rdata_r);
                    end else begin
                        wb_wreg = 1'b0;
                    end
                end
                default: wb_wreg = 1'b0;
            endcase
            if (dmem_req) begin
                dmem_we    = !load_s;
                dmem_addr  = {mem_mem_addr[31:2], 2'b00};
                dmem_sel   = f_sel(mem_aluop, off_s);
                dmem_wdata = load_s ? 32'd0 : f_store_data(mem_aluop, mem_reg2);
            end else begin
                dmem_we = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized scoreboard bench for mem_lsu: a driver pushes expected write-back and bus
// behaviour per op into a queue, a negedge monitor compares whenever an op completes.
module tb_mem_lsu;

    localparam int TIMEOUT = 16;

    localparam logic [7:0] OP_NOP  = 8'b0000_0000;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_LB   = 8'b1110_0000;
    localparam logic [7:0] OP_LH   = 8'b1110_0001;
    localparam logic [7:0] OP_LW   = 8'b1110_0011;
    localparam logic [7:0] OP_LBU  = 8'b1110_0100;
    localparam logic [7:0] OP_LHU  = 8'b1110_0101;
    localparam logic [7:0] OP_SB   = 8'b1110_1000;
    localparam logic [7:0] OP_SH   = 8'b1110_1001;
    localparam logic [7:0] OP_SW   = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        mem_whilo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_reg2;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_sel;
    logic        dmem_ack;
    logic        stallreq;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata, wb_hi, wb_lo;
    logic        wb_whilo, misalign, bus_err;

    mem_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_sel(dmem_sel), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stallreq(stallreq),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
        int          req_cycles;
        logic        wreg;
        logic [31:0] wbdata;
        logic        chk_wbdata;
        logic        whilo;
        logic        mis;
        logic        berr;
        logic [4:0]  wd;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   req_cnt = 0;
    int   stall_cnt = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks the bus each request cycle and the write-back bundle at each completion.
    always @(negedge clk) begin
        if (mon_en) begin
            if (dmem_req) begin
                req_cnt++;
                if (exp_q.size() > 0) begin
                    chk("dmem_addr", dmem_addr, exp_q[0].addr);
                    chk("dmem_sel", 32'(dmem_sel), 32'(exp_q[0].sel));
                    chk("dmem_we", 32'(dmem_we), 32'(exp_q[0].we));
                    if (exp_q[0].we) chk("dmem_wdata", dmem_wdata, exp_q[0].wdata);
                end
            end
            if (stallreq) begin
                stall_cnt++;
                chk("flags_while_stalled", {28'd0, misalign, bus_err, wb_wreg, wb_whilo}, 32'd0);
            end else begin
                chk("spurious_completion", 32'(exp_q.size() == 0), 32'd0);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("req_cycles", 32'(req_cnt), 32'(mon_e.req_cycles));
                    chk("stall_cycles", 32'(stall_cnt), 32'(mon_e.req_cycles));
                    chk("wb_wd", 32'(wb_wd), 32'(mon_e.wd));
                    chk("wb_hi", wb_hi, mon_e.hi);
                    chk("wb_lo", wb_lo, mon_e.lo);
                    chk("wb_wreg", 32'(wb_wreg), 32'(mon_e.wreg));
                    chk("wb_whilo", 32'(wb_whilo), 32'(mon_e.whilo));
                    chk("misalign", 32'(misalign), 32'(mon_e.mis));
                    chk("bus_err", 32'(bus_err), 32'(mon_e.berr));
                    if (mon_e.chk_wbdata) chk("wb_wdata", wb_wdata, mon_e.wbdata);
                end
                req_cnt   = 0;
                stall_cnt = 0;
            end
        end
    end

    // Issue one op (entered and left at posedge+1); k = BUSY cycle carrying ack, 0 = never.
    task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input int k, input logic [31:0] rdata);
        exp_t        x;
        int          bytes, off, busy;
        logic        memop, isload;
        logic [63:0] raw, mask;
        mem_aluop    = op;
        mem_mem_addr = addr;
        mem_reg2     = reg2;
        mem_wd       = 5'($urandom);
        mem_wreg     = 1'($urandom);
        mem_wdata    = $urandom;
        mem_hi       = $urandom;
        mem_lo       = $urandom;
        mem_whilo    = 1'($urandom);
        dmem_ack     = 1'($urandom);
        dmem_rdata   = $urandom;

        memop  = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        isload = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        bytes  = (op inside {OP_LB, OP_LBU, OP_SB}) ? 1 : (op inside {OP_LH, OP_LHU, OP_SH}) ? 2 : 4;
        off    = int'(addr[1:0]);

        x = '{addr: {addr[31:2], 2'b00}, sel: 4'd0, we: memop && !isload, wdata: 32'd0,
              req_cycles: 0, wreg: 1'b0, wbdata: mem_wdata, chk_wbdata: !memop, whilo: 1'b0,
              mis: 1'b0, berr: 1'b0, wd: mem_wd, hi: mem_hi, lo: mem_lo};
        if (!memop) begin
            x.wreg  = mem_wreg;
            x.whilo = mem_whilo;
        end else if ((off % bytes) != 0) begin
            x.mis = 1'b1;
        end else begin
            x.req_cycles = 1 + ((k == 0) ? TIMEOUT - 1 : k);
            x.sel        = 4'(((1 << bytes) - 1) << (4 - bytes - off));
            if (bytes == 1)      x.wdata = {24'd0, reg2[7:0]} * 32'h0101_0101;
            else if (bytes == 2) x.wdata = {16'd0, reg2[15:0]} * 32'h0001_0001;
            else                 x.wdata = reg2;
            if (k == 0) begin
                x.berr = 1'b1;
            end else if (isload) begin
                mask = (64'd1 << (8 * bytes)) - 64'd1;
                raw  = ({32'd0, rdata} >> (8 * (4 - bytes - off))) & mask;
                if ((op == OP_LB || op == OP_LH) && raw[8 * bytes - 1]) raw = raw | ~mask;
                x.wreg       = mem_wreg;
                x.wbdata     = raw[31:0];
                x.chk_wbdata = 1'b1;
            end
        end
        exp_q.push_back(x);

        if (memop && x.mis == 1'b0) begin
            busy = (k == 0) ? TIMEOUT - 1 : k;
            for (int b = 1; b <= busy; b++) begin
                @(posedge clk); #1;
                dmem_ack   = (b == k);
                dmem_rdata = (b == k) ? rdata : $urandom;
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    localparam logic [7:0] OPS [11] = '{OP_NOP, OP_ADDU, OP_OR, OP_LB, OP_LH, OP_LW,
                                        OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

    initial begin
        rst          = 1'b0;
        dmem_ack     = 1'b1;
        dmem_rdata   = 32'hCAFE_F00D;
        mem_aluop    = OP_ADDU;
        mem_wdata    = 32'hDEAD_BEEF;
        mem_wreg     = 1'b1;
        mem_wd       = 5'd9;
        mem_hi       = 32'h1111_2222;
        mem_lo       = 32'h3333_4444;
        mem_whilo    = 1'b1;
        mem_mem_addr = 32'h0000_0100;
        mem_reg2     = 32'h5555_6666;
        #3;
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        chk("rst_wb_wd", 32'(wb_wd), 32'd0);
        chk("rst_wb_hilo", wb_hi | wb_lo | 32'(wb_whilo), 32'd0);
        mem_aluop = OP_LW;
        #1;
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        chk("rst_dmem_bus", dmem_addr | dmem_wdata | 32'(dmem_sel) | 32'(dmem_we), 32'd0);
        @(posedge clk); #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        do_op(OP_ADDU, 32'h0, 32'h0, 1, 32'h0);
        do_op(OP_LB,  32'h0000_0101, 32'h0, 1, 32'h11F2_3344);
        do_op(OP_LBU, 32'h0000_0101, 32'h0, 1, 32'h11F2_3344);
        do_op(OP_SH,  32'h0000_0202, 32'hAAAA_BEEF, 3, 32'h0);
        do_op(OP_LW,  32'h0000_0303, 32'h0, 1, 32'h0);
        do_op(OP_LW,  32'h0000_0400, 32'h0, 0, 32'h0);
        do_op(OP_LW,  32'h0000_0400, 32'h0, TIMEOUT - 1, 32'h8765_4321);
        do_op(OP_LH,  32'h0000_0502, 32'h0, 2, 32'h1234_8001);
        do_op(OP_LHU, 32'h0000_0500, 32'h0, 1, 32'hF00F_1234);
        do_op(OP_SB,  32'h0000_0603, 32'h0000_00A5, 1, 32'h0);
        do_op(OP_SW,  32'h0000_0704, 32'h0BAD_F00D, 4, 32'h0);
        do_op(OP_SH,  32'h0000_0701, 32'h1234_5678, 1, 32'h0);
        do_op(OP_NOP, 32'h0, 32'h0, 1, 32'h0);

        for (int i = 0; i < 150; i++) begin
            int kk;
            kk = ($urandom_range(0, 9) == 0) ? 0 :
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, TIMEOUT - 1) : $urandom_range(1, 3);
            do_op(OPS[$urandom_range(0, 10)], $urandom, $urandom, kk, $urandom);
        end
        mon_en = 1'b0;

        // Reset asserted on the second BUSY cycle of a load that never gets an ack.
        mem_aluop    = OP_LW;
        mem_mem_addr = 32'h0000_0800;
        mem_wreg     = 1'b1;
        mem_wd       = 5'd7;
        mem_wdata    = 32'h7777_7777;
        dmem_ack     = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_req_before_rst", 32'(dmem_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("midbusy_rst_req", 32'(dmem_req), 32'd0);
        chk("midbusy_rst_stall", 32'(stallreq), 32'd0);
        chk("midbusy_rst_wreg", 32'(wb_wreg), 32'd0);
        chk("midbusy_rst_wb", wb_wdata | wb_hi | wb_lo | 32'(wb_wd) | 32'(wb_whilo), 32'd0);
        chk("midbusy_rst_bus", dmem_addr | 32'(dmem_sel), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b1;
        mem_aluop = OP_ADDU;
        mem_wdata = 32'h1234_5678;
        mem_wd    = 5'd5;
        #1;
        chk("post_rst_idle_stall", 32'(stallreq), 32'd0);
        chk("post_rst_idle_req", 32'(dmem_req), 32'd0);
        chk("post_rst_idle_wdata", wb_wdata, 32'h1234_5678);
        chk("post_rst_idle_wreg", 32'(wb_wreg), 32'd1);
        @(posedge clk); #1;
        mon_en = 1'b1;
        do_op(OP_LBU, 32'h0000_0903, 32'h0, 2, 32'h0102_03C4);
        mon_en = 1'b0;

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit; consumes the mem_* bundle produced by the EX/MEM pipeline register and drives the data-memory bus with a valid/ack handshake.
- Non-memory ops pass through to MEM/WB combinationally.
- Loads and stores raise stallreq to the ctrl block until the bus responds.
- Produces the write-back bundle: register, HI/LO, load data, and error flags.

Parameters:
TIMEOUT, 16, max cycles dmem_req may stay high without dmem_ack before abort (>=2)
CNT_W, 5, width of timeout counter (2^CNT_W > TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
mem_wd  in  `RegAddrBus  destination register from EX/MEM
mem_wreg  in  1  GPR write enable from EX/MEM
mem_wdata  in  `RegBus  ALU result from EX/MEM
mem_hi / mem_lo  in  `RegBus  HI/LO values from EX/MEM
mem_whilo  in  1  HI/LO write enable from EX/MEM
mem_aluop  in  `AluOpBus  operation code
mem_mem_addr  in  `RegBus  effective address
mem_reg2  in  `RegBus  store source data
dmem_req  out  1  bus request valid
dmem_we  out  1  1 = store
dmem_addr  out  `RegBus  word address ({addr[31:2],2'b00})
dmem_sel  out  4  byte enables, bit3 = byte at offset 0 (big-endian)
dmem_wdata  out  `RegBus  store data, replicated lanes
dmem_rdata  in  `RegBus  load data, valid with dmem_ack
dmem_ack  in  1  bus completion, sampled at posedge while dmem_req=1
stallreq  out  1  stall request to ctrl
wb_wd  out  `RegAddrBus  destination register to MEM/WB
wb_wreg  out  1  GPR write enable to MEM/WB
wb_wdata  out  `RegBus  write data to MEM/WB
wb_hi / wb_lo  out  `RegBus  HI/LO to MEM/WB
wb_whilo  out  1  HI/LO write enable to MEM/WB
misalign  out  1  misaligned access flag (one cycle)
bus_err  out  1  timeout abort flag (one cycle)

Behaviour:
- Memory ops: `fLB_OP `fLBU_OP `fLH_OP `fLHU_OP `fLW_OP `fSB_OP `fSH_OP `fSW_OP. All other codes, including `fNOP_OP, are non-memory.
- FSM states: IDLE, BUSY, DONE.
  - Registered elements: state, timeout counter, captured rdata, error flag.
  - Reset (rst=0, async) forces IDLE, counter 0, captured data 0, error 0.
  - During reset every output is 0.
- IDLE, non-memory op:
  - wb_* = mem_* combinationally.
  - dmem_req=0, stallreq=0.
- IDLE, memory op, aligned:
  - dmem_req=1, stallreq=1, wb_wreg=0, wb_whilo=0.
  - Next state BUSY, counter cleared.
  - dmem_ack in IDLE is ignored.
- BUSY:
  - Keep dmem_req=1 with addr/sel/we/wdata stable (EX/MEM is stalled); stallreq=1; counter increments each cycle.
  - If dmem_ack=1 at a posedge: capture dmem_rdata, go DONE.
  - If the counter reaches TIMEOUT-1 without ack: drop the request, set error, go DONE.
- DONE:
  - dmem_req=0, stallreq=0.
  - Load: wb_wreg=mem_wreg, wb_wdata=extracted load data.
  - Store: wb_wreg=0.
  - Error: wb_wreg=0, bus_err=1.
  - Next state is always IDLE. EX/MEM advances at the end of DONE, so each access is issued exactly once.
- Alignment: halfword ops need addr[0]=0; word ops need addr[1:0]=00.
  - On violation in IDLE: no request, misalign=1, wb_wreg=0, stallreq=0, stay IDLE. Latency is one cycle.
- Byte lanes (off = addr[1:0]):
  - SB/LB/LBU sel: 00→1000, 01→0100, 10→0010, 11→0001.
  - SH/LH/LHU sel: 00→1100, 10→0011.
  - SW/LW sel: 1111.
- Store data:
  - SB: dmem_wdata = {4{reg2[7:0]}}.
  - SH: dmem_wdata = {2{reg2[15:0]}}.
  - SW: dmem_wdata = reg2.
- Load data: the selected lane is sign-extended for LB/LH and zero-extended for LBU/LHU. LW returns the full word.
- wb_hi, wb_lo, wb_wd always pass through from mem_*. wb_whilo=mem_whilo only in the non-memory IDLE case; otherwise it is 0.
- Ack arriving in the same cycle as the timeout threshold: ack wins.
- Reset asserted mid-BUSY: dmem_req drops immediately (async); no write-back occurs.
- Minimum memory-op latency is 3 cycles: IDLE issue → BUSY with ack → DONE write-back.

Test Plan:
- `fADDU_OP, mem_wdata=0x12345678, wd=5, wreg=1 → same cycle wb_wdata=0x12345678, wb_wd=5, stallreq=0, dmem_req=0.
- `fLB_OP addr=0x101, ack on first BUSY cycle, rdata=0x11F2_3344 → sel=0100, addr=0x100, stallreq high for 2 cycles, DONE wb_wdata=0xFFFFFFF2. Repeat with `fLBU_OP → 0x000000F2.
- `fSH_OP addr=0x202, reg2=0xAAAA_BEEF, ack after 3 BUSY cycles → dmem_we=1, sel=0011, wdata=0xBEEFBEEF held stable, DONE wb_wreg=0.
- `fLW_OP addr=0x303 → misalign=1 for one cycle, dmem_req never asserted, wb_wreg=0, stallreq=0.
- `fLW_OP, no ack, TIMEOUT=16 → dmem_req high 16 cycles then low, bus_err=1 in DONE, wb_wreg=0, back to IDLE; ack on cycle 16 instead → normal load.
- Assert rst=0 on the 2nd BUSY cycle → dmem_req, stallreq and all wb_* drop to 0 without waiting for clk; after release, state is IDLE.
